ula_ctrl_fsm: RTL

- Multicycle control unit that drives the ULA: it is the producer of the 3-bit ULA operation code, where the ULA is the consumer.
- Decodes MIPS-style Op/Funct fields from the instruction register. Sequences fetch, decode, execute, memory and writeback states.
- Emits datapath strobes and mux selects. Handles a req/ack memory handshake with a timeout.
- Sits between the instruction register/memory interface and the 8-bit ULA datapath.

---
 rtl/ula_ctrl_fsm.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/ula_ctrl_fsm.sv
// Multicycle MIPS-style control unit producing the ULA operation code and datapath strobes.
// Optional ANDI_ORI_EN enables andi/ori decode with zero-extended immediates.
module ula_ctrl_fsm #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ack,
  output logic [2:0] ula_control,
  output logic       ula_src_a,
  output logic [1:0] ula_src_b,
  output logic       imm_zext,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] pc_src,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       iord,
  output logic       mem_req,
  output logic       mem_we,
  output logic       illegal,
  output logic       bus_err,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StMemAdr = 4'd3,
    StMemRd  = 4'd4,
    StMemWb  = 4'd5,
    StMemWr  = 4'd6,
    StExecR  = 4'd7,
    StRwb    = 4'd8,
    StExecI  = 4'd9,
    StIwb    = 4'd10,
    StBeq    = 4'd11,
    StJump   = 4'd12
  } state_e;

  localparam logic [7:0] WaitLast = 8'(WAIT_MAX - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       bus_err_q, bus_err_d;
  logic       in_wait, timeout;

  assign in_wait   = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
  // An ack in the last allowed cycle still completes the transfer.
  assign timeout   = in_wait && !mem_ack && (wait_q == WaitLast);
  assign bus_err   = bus_err_q;
  assign state_dbg = state_q;

  always_comb begin
    state_d     = state_q;
    bus_err_d   = bus_err_q;
    ula_control = 3'b010;
    ula_src_a   = 1'b0;
    ula_src_b   = 2'b00;
    imm_zext    = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    pc_src      = 2'b00;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    iord        = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    illegal     = 1'b0;

    case (state_q)
      StIdle: if (!bus_err_q) state_d = StFetch;
      StFetch: begin
        mem_req   = 1'b1;
        ula_src_b = 2'b01;
        if (mem_ack) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = StDecode;
        end
      end
      StDecode: begin
        ula_src_b = 2'b11;
        case (op)
          6'b100011, 6'b101011: state_d = StMemAdr;
          6'b000000:            state_d = StExecR;
          6'b000100:            state_d = StBeq;
          6'b001000:            state_d = StExecI;
`ifdef ANDI_ORI_EN
          6'b001100, 6'b001101: state_d = StExecI;
`endif
          6'b000010:            state_d = StJump;
          default: begin
            illegal = 1'b1;
            state_d = StFetch;
          end
        endcase
      end
      StMemAdr: begin
        ula_src_a = 1'b1;
        ula_src_b = 2'b10;
        state_d   = (op == 6'b100011) ? StMemRd : StMemWr;
      end
      StMemRd: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ack) state_d = StMemWb;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = StFetch;
      end
      StMemWr: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (mem_ack) state_d = StFetch;
      end
      StExecR: begin
        ula_src_a = 1'b1;
        state_d   = StRwb;
        case (funct)
          6'b100000: ula_control = 3'b010;
          6'b100010: ula_control = 3'b110;
          6'b100100: ula_control = 3'b000;
          6'b100101: ula_control = 3'b001;
          6'b100111: ula_control = 3'b011;
          6'b101010: ula_control = 3'b111;
          default: begin
            illegal = 1'b1;
            state_d = StFetch;
          end
        endcase
      end
      StRwb: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = StFetch;
      end
      StExecI: begin
        ula_src_a = 1'b1;
        ula_src_b = 2'b10;
`ifdef ANDI_ORI_EN
        if (op == 6'b001100) begin
          ula_control = 3'b000;
          imm_zext    = 1'b1;
        end else if (op == 6'b001101) begin
          ula_control = 3'b001;
          imm_zext    = 1'b1;
        end
`endif
        state_d = StIwb;
      end
      StIwb: begin
        reg_write = 1'b1;
        state_d   = StFetch;
      end
      StBeq: begin
        ula_src_a   = 1'b1;
        ula_control = 3'b110;
        pc_src      = 2'b01;
        pc_write    = zero;
        state_d     = StFetch;
      end
      StJump: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        state_d  = StFetch;
      end
      default: state_d = StIdle;
    endcase

    if (timeout) begin
      state_d   = StIdle;
      bus_err_d = 1'b1;
    end
  end

  always_comb begin
    if (!in_wait || mem_ack || (state_d != state_q)) wait_d = 8'd0;
    else                                             wait_d = wait_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      wait_q    <= 8'd0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
    end
  end

endmodule
